// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking entry front end: the FSM state
// encoding (also driven out on state_o) and default timing constants.
// ---------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_READY   = 2'd3
  } state_e;

  // Consecutive disagreeing samples before a debounced sensor flips.
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  // Idle cycles tolerated between password digits (timeout build only).
  localparam int TIMEOUT_CYCLES_DEF  = 64;

endpackage : parking_pkg

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// Debounces one raw sensor. o_stable takes the value of i_raw only after
// i_raw has disagreed with o_stable on DEBOUNCE_CYCLES consecutive clocks;
// any agreeing sample restarts the count. i_raw is expected to be
// synchronous to clk already.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_raw    in   raw sensor level
//   o_stable out  debounced sensor level (0 out of reset)
// ---------------------------------------------------------------------------
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // NOTE: every register gets an explicit value in the async reset branch and
  // is updated only with non-blocking assignments, so all flops in the block
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_raw != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        r_stable <= i_raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_stable = r_stable;

endmodule : sensor_debounce

// File: rtl/parking_entry_frontend.sv
// ---------------------------------------------------------------------------
// parking_entry_frontend
// Front end of the parking entry gate: debounces the entry/exit sensors and
// runs a two-digit password capture FSM. entry_sensor is raised to the
// parking controller only once a car is present and both digits are in.
//
// Optional feature (macro PASSWORD_TIMEOUT_EN): a digit-entry timeout that
// drops back to WAIT_D1 after TIMEOUT_CYCLES idle cycles in a WAIT state.
// Without the macro the WAIT states wait indefinitely and timeout_err is 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   entry_raw    in   raw entry-gate sensor
//   exit_raw     in   raw exit-gate sensor
//   key_valid    in   one-cycle strobe, key_data holds a digit
//   key_data     in   2-bit password digit
//   key_clear    in   one-cycle strobe, discard digits entered so far
//   entry_sensor out  registered, 1 exactly while in READY
//   exit_sensor  out  debounced exit sensor
//   password_1   out  first captured digit
//   password_2   out  second captured digit
//   state_o      out  current FSM state code
//   timeout_err  out  one-cycle pulse on a digit-entry timeout
// ---------------------------------------------------------------------------
module parking_entry_frontend
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_raw,
  input  logic       exit_raw,
  input  logic       key_valid,
  input  logic [1:0] key_data,
  input  logic       key_clear,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic [1:0] state_o,
  output logic       timeout_err
);

  state_e     r_state, w_next_state;
  logic [1:0] r_pw1, r_pw2, w_next_pw1, w_next_pw2;
  logic       r_entry_sensor;
  logic       r_entry_prev;
  logic       w_entry_stable, w_exit_stable;
  logic       w_entry_rise, w_entry_fall;
  logic       w_tmo_hit;

  // ---- sensor debouncing ---------------------------------------------------
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk      (clk),
    .rst_n    (rst),
    .i_raw    (entry_raw),
    .o_stable (w_entry_stable)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk      (clk),
    .rst_n    (rst),
    .i_raw    (exit_raw),
    .o_stable (w_exit_stable)
  );

  // Edge detect on the debounced entry level. The previous-value register
  // resets to 0, so a sensor already high at reset release is seen as a
  // fresh rising edge once it has been debounced.
  assign w_entry_rise = w_entry_stable & ~r_entry_prev;
  assign w_entry_fall = ~w_entry_stable & r_entry_prev;

  // ---- next-state / datapath -----------------------------------------------
  // Priority: debounced entry fall > key_clear > key_valid > timeout.
  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_pw1   = r_pw1;
    w_next_pw2   = r_pw2;
    if (w_entry_fall && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_next_pw1   = 2'd0;
      w_next_pw2   = 2'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_entry_rise) w_next_state = ST_WAIT_D1;
        end
        ST_WAIT_D1: begin
          // key_clear here has nothing to discard; it just blocks key_valid.
          if (!key_clear) begin
            if (key_valid) begin
              w_next_pw1   = key_data;
              w_next_state = ST_WAIT_D2;
            end else if (w_tmo_hit) begin
              w_next_pw1 = 2'd0;
              w_next_pw2 = 2'd0;
            end
          end
        end
        ST_WAIT_D2: begin
          if (key_clear) begin
            w_next_pw1   = 2'd0;
            w_next_state = ST_WAIT_D1;
          end else if (key_valid) begin
            w_next_pw2   = key_data;
            w_next_state = ST_READY;
          end else if (w_tmo_hit) begin
            w_next_pw1   = 2'd0;
            w_next_pw2   = 2'd0;
            w_next_state = ST_WAIT_D1;
          end
        end
        ST_READY: ;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_pw1          <= 2'd0;
      r_pw2          <= 2'd0;
      r_entry_sensor <= 1'b0;
      r_entry_prev   <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_pw1          <= w_next_pw1;
      r_pw2          <= w_next_pw2;
      // Registered from next state so it tracks READY with no input path.
      r_entry_sensor <= (w_next_state == ST_READY);
      r_entry_prev   <= w_entry_stable;
    end
  end

  // ---- optional digit-entry timeout ----------------------------------------
`ifdef PASSWORD_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_timeout_err;
  logic              w_in_wait;

  assign w_in_wait = (r_state == ST_WAIT_D1) || (r_state == ST_WAIT_D2);
  // Fires on the cycle the count would reach TIMEOUT_CYCLES, and only when
  // no higher-priority event claims the cycle.
  assign w_tmo_hit = w_in_wait && !w_entry_fall && !key_clear && !key_valid &&
                     (r_tcnt == TCNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_tmo_hit;
      if (!w_in_wait || key_valid || key_clear || w_tmo_hit ||
          (w_next_state != r_state)) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_tmo_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---- outputs ---------------------------------------------------------------
  assign entry_sensor = r_entry_sensor;
  assign exit_sensor  = w_exit_stable;
  assign password_1   = r_pw1;
  assign password_2   = r_pw2;
  assign state_o      = r_state;

endmodule : parking_entry_frontend

// File: tb/tb_parking_entry_frontend.sv
// ---------------------------------------------------------------------------
// tb_parking_entry_frontend
// Directed bench for parking_entry_frontend with default parameters
// (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64). Inputs are driven and outputs
// sampled on the falling clock edge. Build with PASSWORD_TIMEOUT_EN defined
// to exercise the timeout; otherwise the bench checks that none occurs.
// ---------------------------------------------------------------------------
module tb_parking_entry_frontend;

  logic       clk;
  logic       rst;
  logic       entry_raw;
  logic       exit_raw;
  logic       key_valid;
  logic [1:0] key_data;
  logic       key_clear;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic [1:0] state_o;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  parking_entry_frontend dut (
    .clk          (clk),
    .rst          (rst),
    .entry_raw    (entry_raw),
    .exit_raw     (exit_raw),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .key_clear    (key_clear),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .password_1   (password_1),
    .password_2   (password_2),
    .state_o      (state_o),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot {state_o, entry_sensor, exit_sensor, password_1, password_2, timeout_err}
  function automatic logic [8:0] snap();
    return {state_o, entry_sensor, exit_sensor, password_1, password_2, timeout_err};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [1:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick(1);
    key_valid = 1'b0;
    key_data  = 2'd0;
  endtask

  task automatic press_clear();
    key_clear = 1'b1;
    tick(1);
    key_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; entry_raw = 1'b0; exit_raw = 1'b0;
    key_valid = 1'b0; key_data = 2'd0; key_clear = 1'b0;
    tick(2);
    n_checks++;
    if (snap() !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", snap(), 9'd0);
    end
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (snap() !== 9'd0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b expected %b", snap(), 9'd0);
    end
  endtask

  task automatic test_glitch();
    entry_raw = 1'b1;
    tick(3);
    entry_raw = 1'b0;
    tick(10);
    n_checks++;
    if (state_o !== 2'd0 || entry_sensor !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject: state=%0d entry_sensor=%b expected 0/0", state_o, entry_sensor);
    end
  endtask

  task automatic test_normal_entry();
    entry_raw = 1'b1;
    tick(4);
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++; $display("FAIL entry_latency_early: state=%0d expected 0", state_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++; $display("FAIL entry_latency: state=%0d expected 1", state_o);
    end
    press_key(2'b01);
    n_checks++;
    if (state_o !== 2'd2 || password_1 !== 2'b01 || entry_sensor !== 1'b0) begin
      n_fail++; $display("FAIL first_digit: state=%0d pw1=%b es=%b expected 2/01/0", state_o, password_1, entry_sensor);
    end
    press_key(2'b01);
    n_checks++;
    if (snap() !== {2'd3, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL normal_ready: got %b expected %b", snap(), {2'd3, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0});
    end
  endtask

  task automatic test_car_leaves();
    entry_raw = 1'b0;
    tick(4);
    n_checks++;
    if (state_o !== 2'd3 || entry_sensor !== 1'b1) begin
      n_fail++; $display("FAIL leave_early: state=%0d es=%b expected 3/1", state_o, entry_sensor);
    end
    tick(1);
    n_checks++;
    if (snap() !== 9'd0) begin
      n_fail++; $display("FAIL leave_idle: got %b expected %b", snap(), 9'd0);
    end
    exit_raw = 1'b1;
    tick(3);
    n_checks++;
    if (exit_sensor !== 1'b0) begin
      n_fail++; $display("FAIL exit_early: exit_sensor=%b expected 0", exit_sensor);
    end
    tick(2);
    n_checks++;
    if (exit_sensor !== 1'b1 || state_o !== 2'd0) begin
      n_fail++; $display("FAIL exit_debounced: exit_sensor=%b state=%0d expected 1/0", exit_sensor, state_o);
    end
    exit_raw = 1'b0;
    tick(5);
    n_checks++;
    if (exit_sensor !== 1'b0) begin
      n_fail++; $display("FAIL exit_release: exit_sensor=%b expected 0", exit_sensor);
    end
  endtask

  task automatic test_clear();
    entry_raw = 1'b1;
    tick(5);
    press_clear();
    n_checks++;
    if (state_o !== 2'd1 || password_1 !== 2'b00) begin
      n_fail++; $display("FAIL clear_in_d1: state=%0d pw1=%b expected 1/00", state_o, password_1);
    end
    press_key(2'b10);
    n_checks++;
    if (state_o !== 2'd2 || password_1 !== 2'b10) begin
      n_fail++; $display("FAIL clear_digit1: state=%0d pw1=%b expected 2/10", state_o, password_1);
    end
    press_clear();
    n_checks++;
    if (state_o !== 2'd1 || password_1 !== 2'b00) begin
      n_fail++; $display("FAIL clear_in_d2: state=%0d pw1=%b expected 1/00", state_o, password_1);
    end
    press_key(2'b11);
    press_key(2'b01);
    n_checks++;
    if (snap() !== {2'd3, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL clear_ready: got %b expected %b", snap(), {2'd3, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0});
    end
    press_key(2'b10);
    press_clear();
    n_checks++;
    if (state_o !== 2'd3 || password_1 !== 2'b11 || password_2 !== 2'b01) begin
      n_fail++; $display("FAIL keys_ignored_ready: state=%0d pw=%b/%b expected 3/11/01", state_o, password_1, password_2);
    end
  endtask

  task automatic test_priority();
    entry_raw = 1'b0;
    tick(5);
    press_key(2'b11);
    n_checks++;
    if (state_o !== 2'd0 || password_1 !== 2'b00) begin
      n_fail++; $display("FAIL keys_ignored_idle: state=%0d pw1=%b expected 0/00", state_o, password_1);
    end
    entry_raw = 1'b1;
    tick(5);
    press_key(2'b10);
    key_valid = 1'b1; key_data = 2'b11; key_clear = 1'b1;
    tick(1);
    key_valid = 1'b0; key_data = 2'b00; key_clear = 1'b0;
    n_checks++;
    if (state_o !== 2'd1 || password_1 !== 2'b00 || password_2 !== 2'b00) begin
      n_fail++; $display("FAIL clear_beats_valid: state=%0d pw=%b/%b expected 1/00/00", state_o, password_1, password_2);
    end
    press_key(2'b01);
    entry_raw = 1'b0;
    tick(4);
    press_key(2'b11);
    n_checks++;
    if (state_o !== 2'd0 || password_1 !== 2'b00 || password_2 !== 2'b00) begin
      n_fail++; $display("FAIL fall_beats_valid: state=%0d pw=%b/%b expected 0/00/00", state_o, password_1, password_2);
    end
    entry_raw = 1'b1;
    tick(5);
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first  = -1;
    press_key(2'b10);
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (timeout_err === 1'b1) begin
        if (first < 0) first = i;
        pulses++;
      end
    end
`ifdef PASSWORD_TIMEOUT_EN
    n_checks++;
    if (pulses !== 1 || first !== 63) begin
      n_fail++; $display("FAIL timeout_pulse: pulses=%0d first=%0d expected 1/63", pulses, first);
    end
    n_checks++;
    if (state_o !== 2'd1 || password_1 !== 2'b00) begin
      n_fail++; $display("FAIL timeout_state: state=%0d pw1=%b expected 1/00", state_o, password_1);
    end
`else
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL no_timeout_pulse: pulses=%0d expected 0", pulses);
    end
    n_checks++;
    if (state_o !== 2'd2 || password_1 !== 2'b10) begin
      n_fail++; $display("FAIL no_timeout_state: state=%0d pw1=%b expected 2/10", state_o, password_1);
    end
`endif
  endtask

  task automatic test_async_reset();
    press_clear();
    press_key(2'b11);
    n_checks++;
    if (state_o !== 2'd2 || password_1 !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_d2: state=%0d pw1=%b expected 2/11", state_o, password_1);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (snap() !== 9'd0) begin
      n_fail++; $display("FAIL async_reset_immediate: got %b expected %b", snap(), 9'd0);
    end
    tick(2);
    rst = 1'b1;
    tick(4);
    n_checks++;
    if (state_o !== 2'd0 || password_1 !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_early: state=%0d pw1=%b expected 0/00", state_o, password_1);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd1 || password_1 !== 2'b00 || entry_sensor !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_rise: state=%0d pw1=%b es=%b expected 1/00/0", state_o, password_1, entry_sensor);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_normal_entry();
    test_car_leaves();
    test_clear();
    test_priority();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_parking_entry_frontend

// File: doc/parking_entry_frontend.md
PARKING_ENTRY_FRONTEND -- requirements
Module: parking_entry_frontend

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL be: default 4; consecutive stable cycles needed before a debounced sensor changes.
REQ-003 Parameter TIMEOUT_CYCLES SHALL be: default 64; idle cycles allowed between password digits (used only under REQ-030).
REQ-004 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- entry_raw  in  1  raw entry-gate sensor
- exit_raw  in  1  raw exit-gate sensor
- key_valid  in  1  one-cycle strobe: key_data holds a digit
- key_data  in  2  password digit
- key_clear  in  1  one-cycle strobe: discard digits entered so far
- entry_sensor  out  1  car present AND both digits captured; feeds the parking controller
- exit_sensor  out  1  debounced exit sensor; feeds the parking controller
- password_1  out  2  first captured digit
- password_2  out  2  second captured digit
- state_o  out  2  current FSM state code
- timeout_err  out  1  one-cycle pulse on a digit-entry timeout

Function
REQ-010 Each raw sensor SHALL be debounced independently: the stable value takes the raw value only after raw differs from stable on DEBOUNCE_CYCLES consecutive clocks; any agreeing sample resets the count.
REQ-011 The FSM SHALL have states IDLE=0, WAIT_D1=1, WAIT_D2=2, READY=3, visible on state_o.
REQ-012 IDLE -> WAIT_D1 SHALL occur on the cycle after the debounced entry rises.
REQ-013 WAIT_D1 with key_valid SHALL capture key_data into password_1 and go to WAIT_D2.
REQ-014 WAIT_D2 with key_valid SHALL capture key_data into password_2 and go to READY.
REQ-015 WAIT_D2 with key_clear SHALL zero password_1 and return to WAIT_D1.
REQ-016 WAIT_D1 with key_clear SHALL remain in WAIT_D1 with no change.
REQ-017 A debounced entry fall in any non-IDLE state SHALL go to IDLE and zero both passwords.
REQ-018 key_valid and key_clear SHALL be ignored in IDLE and READY.
REQ-019 entry_sensor SHALL be 1 exactly while state is READY; it is registered and has no combinational path from inputs.
REQ-020 exit_sensor SHALL equal the debounced exit value in every state.
REQ-021 Priority within one cycle SHALL be: debounced entry fall > key_clear > key_valid > timeout.
REQ-022 The latency from a raw entry edge to a state change SHALL be DEBOUNCE_CYCLES+1 clocks.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE; all outputs 0; debounce counters, stable values and timeout counter 0.
REQ-026 Reset asserted mid-entry SHALL discard captured digits; no output is restored after reset release.
REQ-027 After rst deasserts, a raw sensor already at 1 SHALL be treated as a new rising edge and debounced normally.

Configuration
REQ-030 With PASSWORD_TIMEOUT_EN defined, a counter SHALL:
- count cycles spent in WAIT_D1 or WAIT_D2;
- clear on any key_valid, key_clear, or state change;
- on reaching TIMEOUT_CYCLES, pulse timeout_err for 1 cycle, zero both passwords, and go to WAIT_D1.
REQ-031 Without PASSWORD_TIMEOUT_EN, the timeout counter SHALL be absent and timeout_err tied to 0; WAIT states wait indefinitely.

Structure
REQ-035 The shared package parking_pkg SHALL hold the state encoding typedef and the default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
REQ-036 Debouncing SHALL be a sub-module, sensor_debounce, instantiated twice (entry, exit).

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
- Glitch rejection: entry_raw high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> state_o stays 0 and entry_sensor stays 0.
- Normal entry: entry_raw held 1; after transition to WAIT_D1, key_valid with key_data=01 twice -> password_1=01, password_2=01, state_o=3, entry_sensor=1.
- Clear: digits 10 then key_clear in WAIT_D2 -> password_1=00, state_o=1; then 11,01 -> READY with 11/01.
- Car leaves: entry_raw to 0 in READY -> after 5 cycles state_o=0, entry_sensor=0, passwords=00; exit_raw 1 -> exit_sensor=1 five cycles later.
- Timeout (macro on, TIMEOUT_CYCLES=64): one digit then 64 idle cycles -> timeout_err pulses once, state_o=1, password_1=00.
- Async reset in WAIT_D2: rst low between clock edges -> all outputs 0 immediately; entry_raw still 1 after release -> WAIT_D1 after 5 cycles.
